// File: rtl/projectile_scheduler_pkg.sv
// Shared types and default sizing for the projectile slot scheduler.
package projectile_scheduler_pkg;

    typedef enum logic {
        OWN_PLAYER = 1'b0,
        OWN_ENEMY  = 1'b1
    } owner_e;

    localparam int PROJ_SLOTS     = 4;
    localparam int PROJ_OWNER_CAP = 2;
    localparam int PROJ_COOLDOWN  = 8;
    localparam int PROJ_LIFETIME  = 64;

    // Round-robin helper: the owner that is not the one given.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_PLAYER) ? OWN_ENEMY : OWN_PLAYER;
    endfunction

endpackage

// File: rtl/projectile_scheduler_if.sv
// Fire-request / grant / slot-status bundle between GameControl and the scheduler.
interface projectile_scheduler_if
    import projectile_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = PROJ_SLOTS
);
    localparam int SW = $clog2(NUM_SLOTS);

    logic                 i_enable;
    logic                 i_frame_tick;
    logic                 i_p_req;
    logic                 i_e_req;
    logic                 i_release_valid;
    logic [SW-1:0]        i_release_slot;
    logic                 o_p_grant;
    logic                 o_e_grant;
    logic [SW-1:0]        o_grant_slot;
    logic [NUM_SLOTS-1:0] o_slot_valid;
    logic [NUM_SLOTS-1:0] o_slot_owner;

    modport master (
        output i_enable, i_frame_tick, i_p_req, i_e_req, i_release_valid, i_release_slot,
        input  o_p_grant, o_e_grant, o_grant_slot, o_slot_valid, o_slot_owner
    );

    modport slave (
        input  i_enable, i_frame_tick, i_p_req, i_e_req, i_release_valid, i_release_slot,
        output o_p_grant, o_e_grant, o_grant_slot, o_slot_valid, o_slot_owner
    );

endinterface

// File: rtl/projectile_slot.sv
// One projectile slot: live flag, owner and remaining lifetime in frame ticks.
module projectile_slot
    import projectile_scheduler_pkg::*;
#(
    parameter int LIFETIME = PROJ_LIFETIME
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_clear,
    input  logic   i_load,
    input  owner_e i_load_owner,
    input  logic   i_tick,
    input  logic   i_release,
    output logic   o_valid,
    output owner_e o_owner
);
    localparam int LTW = $clog2(LIFETIME + 1);

    logic           valid_q, valid_d;
    owner_e         owner_q, owner_d;
    logic [LTW-1:0] life_q, life_d;

    // Flush beats load; a fresh load ignores a coincident tick; release and
    // expiry in the same cycle both just clear the live flag once.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        life_d  = life_q;
        if (i_clear) begin
            valid_d = 1'b0;
            owner_d = OWN_PLAYER;
            life_d  = '0;
        end else if (i_load) begin
            valid_d = 1'b1;
            owner_d = i_load_owner;
            life_d  = LTW'(LIFETIME);
        end else if (valid_q) begin
            if (i_release) begin
                valid_d = 1'b0;
                life_d  = '0;
            end else if (i_tick) begin
                life_d = life_q - LTW'(1);
                if (life_q == LTW'(1)) valid_d = 1'b0;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            owner_q <= OWN_PLAYER;
            life_q  <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            life_q  <= life_d;
        end
    end

    assign o_valid = valid_q;
    assign o_owner = owner_q;

endmodule

// File: rtl/projectile_scheduler.sv
// Round-robin allocator of a shared projectile pool between player and enemy,
// with per-owner cooldown and slot cap; slots age on frame ticks.
module projectile_scheduler
    import projectile_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = PROJ_SLOTS,
    parameter int OWNER_CAP = PROJ_OWNER_CAP,
    parameter int COOLDOWN  = PROJ_COOLDOWN,
    parameter int LIFETIME  = PROJ_LIFETIME
) (
    input  logic                   clk,
    input  logic                   rst_n,
    projectile_scheduler_if.slave  bus
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int LW = SW + 1;
    localparam int CW = $clog2(COOLDOWN + 1);

    logic [NUM_SLOTS-1:0] slot_valid;
    owner_e               slot_owner [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] load_vec;
    logic [NUM_SLOTS-1:0] rel_vec;

    logic [LW-1:0] p_live, e_live;
    logic          any_free;
    logic [SW-1:0] free_idx;
    logic          p_elig, e_elig, win_p, win_e, grant;
    owner_e        winner;

    logic [CW-1:0] p_cd_q, p_cd_d, e_cd_q, e_cd_d;
    owner_e        prio_q, prio_d;
    logic          p_grant_q, p_grant_d, e_grant_q, e_grant_d;
    logic [SW-1:0] grant_slot_q, grant_slot_d;

    // Live counts per owner and lowest free slot, all from registered slot state.
    always_comb begin
        p_live   = '0;
        e_live   = '0;
        free_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid[i]) begin
                if (slot_owner[i] == OWN_ENEMY) e_live = e_live + LW'(1);
                else                            p_live = p_live + LW'(1);
            end
        end
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_valid[i]) free_idx = SW'(i);
        end
        any_free = ~&slot_valid;
    end

    // Eligibility and round-robin pick; at most one winner per cycle.
    always_comb begin
        p_elig = bus.i_enable && bus.i_p_req && (p_cd_q == '0)
                 && (p_live < LW'(OWNER_CAP)) && any_free;
        e_elig = bus.i_enable && bus.i_e_req && (e_cd_q == '0)
                 && (e_live < LW'(OWNER_CAP)) && any_free;
        win_p  = p_elig && (!e_elig || prio_q == OWN_PLAYER);
        win_e  = e_elig && (!p_elig || prio_q == OWN_ENEMY);
        grant  = win_p || win_e;
        winner = win_e ? OWN_ENEMY : OWN_PLAYER;
    end

    // Per-slot load/release strobes.
    always_comb begin
        load_vec = '0;
        rel_vec  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_vec[i] = grant && (free_idx == SW'(i));
            rel_vec[i]  = bus.i_release_valid && (bus.i_release_slot == SW'(i));
        end
    end

    // Cooldowns, priority and grant outputs; disable flushes everything.
    always_comb begin
        p_cd_d       = p_cd_q;
        e_cd_d       = e_cd_q;
        prio_d       = prio_q;
        p_grant_d    = win_p;
        e_grant_d    = win_e;
        grant_slot_d = grant ? free_idx : '0;
        if (!bus.i_enable) begin
            p_cd_d = '0;
            e_cd_d = '0;
            prio_d = OWN_PLAYER;
        end else begin
            if (win_p)                                 p_cd_d = CW'(COOLDOWN);
            else if (bus.i_frame_tick && p_cd_q != '0) p_cd_d = p_cd_q - CW'(1);
            if (win_e)                                 e_cd_d = CW'(COOLDOWN);
            else if (bus.i_frame_tick && e_cd_q != '0) e_cd_d = e_cd_q - CW'(1);
            if (grant) prio_d = other_owner(prio_q);
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_cd_q       <= '0;
            e_cd_q       <= '0;
            prio_q       <= OWN_PLAYER;
            p_grant_q    <= 1'b0;
            e_grant_q    <= 1'b0;
            grant_slot_q <= '0;
        end else begin
            p_cd_q       <= p_cd_d;
            e_cd_q       <= e_cd_d;
            prio_q       <= prio_d;
            p_grant_q    <= p_grant_d;
            e_grant_q    <= e_grant_d;
            grant_slot_q <= grant_slot_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        projectile_slot #(.LIFETIME(LIFETIME)) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clear      (!bus.i_enable),
            .i_load       (load_vec[g]),
            .i_load_owner (winner),
            .i_tick       (bus.i_frame_tick),
            .i_release    (rel_vec[g]),
            .o_valid      (slot_valid[g]),
            .o_owner      (slot_owner[g])
        );
        assign bus.o_slot_owner[g] = (slot_owner[g] == OWN_ENEMY);
    end

    assign bus.o_slot_valid = slot_valid;
    assign bus.o_p_grant    = p_grant_q;
    assign bus.o_e_grant    = e_grant_q;
    assign bus.o_grant_slot = grant_slot_q;

endmodule
